grid_renderer: RTL and testbench



---
 rtl/grid_renderer.sv | 257 +++++++++++++++++++++++++
 tb/tb_grid_renderer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_renderer.sv
// grid_renderer: paints a COLS x ROWS grid of square cells into a pixel
// frame adapter. After the display reports ready (sync), every cell is filled
// once in C_OFF. Afterwards, queued draw requests repaint single cells in the
// colour selected by the request state.
//
// Ports
//   CLOCK_50   sole clock, rising edge
//   nReset     asynchronous active-low reset
//   sync       display ready; starts the power-up fill
//   req_valid  draw request present
//   req_col    target column
//   req_row    target row
//   req_state  cell state, selects the colour
//   req_ready  request queue not full
//   req_err    one-cycle pulse after an out-of-range request is accepted
//   busy       painting (power-up fill or cell draw)
//   init_done  power-up fill complete
//   pix_x      registered pixel x
//   pix_y      registered pixel y
//   pix_color  registered pixel colour
//   pix_write  registered pixel write strobe
module grid_renderer #(
  parameter int COLS                = 12,
  parameter int ROWS                = 12,
  parameter int CELL                = 30,
  parameter int PITCH               = 33,
  parameter int X0                  = 214,
  parameter int Y0                  = 32,
  parameter int CDEPTH              = 9,
  parameter logic [CDEPTH-1:0] C_OFF    = 9'd7,
  parameter logic [CDEPTH-1:0] C_ON     = 9'h1FF,
  parameter logic [CDEPTH-1:0] C_PLAY   = 9'h1C0,
  parameter logic [CDEPTH-1:0] C_CURSOR = 9'h038,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic              CLOCK_50,
  input  logic              nReset,
  input  logic              sync,
  input  logic              req_valid,
  input  logic [3:0]        req_col,
  input  logic [3:0]        req_row,
  input  logic [1:0]        req_state,
  output logic              req_ready,
  output logic              req_err,
  output logic              busy,
  output logic              init_done,
  output logic [9:0]        pix_x,
  output logic [8:0]        pix_y,
  output logic [CDEPTH-1:0] pix_color,
  output logic              pix_write
);

  localparam logic [1:0] S_INIT_WAIT = 2'd0;
  localparam logic [1:0] S_INIT_DRAW = 2'd1;
  localparam logic [1:0] S_IDLE      = 2'd2;
  localparam logic [1:0] S_DRAW      = 2'd3;

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [8:0] LAST_D   = 9'(CELL - 1);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  // Request queue: entry layout {col[9:6], row[5:2], state[1:0]}.
  logic [9:0]  fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        fifo_full, fifo_empty;
  logic [9:0]  head;

  logic [1:0]  state_q, state_d;
  logic [3:0]  col_q, col_d;
  logic [3:0]  row_q, row_d;
  logic [1:0]  cst_q, cst_d;
  logic [8:0]  dx_q, dx_d;
  logic [8:0]  dy_q, dy_d;
  logic        init_done_q, init_done_d;
  logic        req_err_q, req_err_d;
  logic        rst_done_q;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [8:0]  pix_y_q, pix_y_d;
  logic [CDEPTH-1:0] pix_color_q, pix_color_d;
  logic        pix_write_q, pix_write_d;

  logic        accept, in_range, push, pop, cell_last;
  logic [10:0] x_full, y_full;

  function automatic logic [CDEPTH-1:0] state_colour(input logic [1:0] s);
    case (s)
      2'd0:    return C_OFF;
      2'd1:    return C_ON;
      2'd2:    return C_PLAY;
      default: return C_CURSOR;
    endcase
  endfunction

  // The extra pointer bit tells full from empty when the indices match.
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];

  // Ready is held low until the first edge after reset release.
  assign req_ready  = rst_done_q && !fifo_full;
  assign accept     = req_valid && req_ready;
  assign in_range   = ({1'b0, req_col} < 5'(COLS)) && ({1'b0, req_row} < 5'(ROWS));
  assign push       = accept && in_range;
  assign req_err_d  = accept && !in_range;

  assign cell_last  = (dx_q == LAST_D) && (dy_q == LAST_D);
  assign x_full     = 11'(X0) + 11'(col_q) * 11'(PITCH) + 11'(dx_q);
  assign y_full     = 11'(Y0) + 11'(row_q) * 11'(PITCH) + 11'(dy_q);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cst_d       = cst_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    init_done_d = init_done_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    pix_write_d = 1'b0;
    pop         = 1'b0;

    case (state_q)
      S_INIT_WAIT: begin
        if (sync) begin
          state_d = S_INIT_DRAW;
          col_d   = '0;
          row_d   = '0;
          dx_d    = '0;
          dy_d    = '0;
        end
      end

      S_INIT_DRAW: begin
        pix_write_d = 1'b1;
        pix_x_d     = 10'(x_full);
        pix_y_d     = 9'(y_full);
        pix_color_d = C_OFF;
        if (cell_last) begin
          dx_d = '0;
          dy_d = '0;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d       = '0;
              state_d     = S_IDLE;
              init_done_d = 1'b1;
            end else begin
              row_d = row_q + 4'd1;
            end
          end else begin
            col_d = col_q + 4'd1;
          end
        end else if (dx_q == LAST_D) begin
          dx_d = '0;
          dy_d = dy_q + 9'd1;
        end else begin
          dx_d = dx_q + 9'd1;
        end
      end

      S_IDLE: begin
        pop = !fifo_empty;
      end

      default: begin // S_DRAW
        pix_write_d = 1'b1;
        pix_x_d     = 10'(x_full);
        pix_y_d     = 9'(y_full);
        pix_color_d = state_colour(cst_q);
        if (cell_last) begin
          // Chain straight into the next queued cell so writes stay gapless.
          pop     = !fifo_empty;
          state_d = S_IDLE;
          dx_d    = '0;
          dy_d    = '0;
        end else if (dx_q == LAST_D) begin
          dx_d = '0;
          dy_d = dy_q + 9'd1;
        end else begin
          dx_d = dx_q + 9'd1;
        end
      end
    endcase

    if (pop) begin
      state_d = S_DRAW;
      col_d   = head[9:6];
      row_d   = head[5:2];
      cst_d   = head[1:0];
      dx_d    = '0;
      dy_d    = '0;
    end
  end

  assign wr_ptr_d = wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_INIT_WAIT;
      col_q       <= '0;
      row_q       <= '0;
      cst_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      init_done_q <= 1'b0;
      req_err_q   <= 1'b0;
      rst_done_q  <= 1'b0;
      pix_x_q     <= 10'(X0);
      pix_y_q     <= 9'(Y0);
      pix_color_q <= C_OFF;
      pix_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cst_q       <= cst_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      init_done_q <= init_done_d;
      req_err_q   <= req_err_d;
      rst_done_q  <= 1'b1;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      pix_write_q <= pix_write_d;
    end
  end

  // NOTE: the queue storage has no reset; resetting the pointers empties the
  // queue, and stale entries are never read.
  always_ff @(posedge CLOCK_50) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {req_col, req_row, req_state};
  end

  assign busy      = (state_q == S_INIT_DRAW) || (state_q == S_DRAW);
  assign init_done = init_done_q;
  assign req_err   = req_err_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign pix_write = pix_write_q;

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer. A reduced 4x3 grid keeps the two
// power-up fills short; cell size, pitch, origin and colours are the defaults,
// so per-cell coordinates match the full-size grid.
module tb_grid_renderer;

  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int CELL  = 30;
  localparam int PITCH = 33;
  localparam int X0    = 214;
  localparam int Y0    = 32;
  localparam int NPIX  = CELL * CELL;
  localparam int NINIT = COLS * ROWS * NPIX;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       sync;
  logic       req_valid;
  logic [3:0] req_col, req_row;
  logic [1:0] req_state;
  logic       req_ready, req_err, busy, init_done, pix_write;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [8:0] pix_color;

  grid_renderer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .CLOCK_50 (clk),
    .nReset   (n_reset),
    .sync     (sync),
    .req_valid(req_valid),
    .req_col  (req_col),
    .req_row  (req_row),
    .req_state(req_state),
    .req_ready(req_ready),
    .req_err  (req_err),
    .busy     (busy),
    .init_done(init_done),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_color(pix_color),
    .pix_write(pix_write)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int x; int y; int c; int cyc;} wr_t;
  typedef struct {int c; int r; int s;} rq_t;
  wr_t cap[$];

  always @(negedge clk)
    if (pix_write === 1'b1) cap.push_back('{int'(pix_x), int'(pix_y), int'(pix_color), cyc});

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_colour(input int st);
    case (st)
      0:       return 'h007;
      1:       return 'h1FF;
      2:       return 'h1C0;
      default: return 'h038;
    endcase
  endfunction

  function automatic wr_t at(input int i);
    if (i >= 0 && i < cap.size()) return cap[i];
    return '{-1, -1, -1, -1};
  endfunction

  // Mismatching pixels of one cell stored at cap[idx .. idx+NPIX-1].
  function automatic int cell_bad(input int idx, input int col, input int row, input int st);
    int bad = 0;
    for (int dy = 0; dy < CELL; dy++)
      for (int dx = 0; dx < CELL; dx++) begin
        wr_t e = at(idx + dy * CELL + dx);
        if (e.x != X0 + col * PITCH + dx || e.y != Y0 + row * PITCH + dy ||
            e.c != exp_colour(st)) bad++;
      end
    return bad;
  endfunction

  function automatic int init_bad();
    int bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) bad += cell_bad((r * COLS + c) * NPIX, c, r, 0);
    return bad;
  endfunction

  // Writes in cap[lo .. hi-1] that are not on consecutive cycles.
  function automatic int gaps(input int lo, input int hi);
    int g = 0;
    for (int i = lo + 1; i < hi; i++) if (at(i).cyc != at(i - 1).cyc + 1) g++;
    return g;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int b = budget;
    while (cap.size() < n && b > 0) begin
      step();
      b--;
    end
  endtask

  // Presents one request and returns the cycle of the accepting edge.
  task automatic send(input int c, input int r, input int s, output int n);
    int b = 3000;
    req_valid = 1'b1;
    req_col   = 4'(c);
    req_row   = 4'(r);
    req_state = 2'(s);
    @(negedge clk);
    while (!req_ready && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (b == 0) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    n = cyc;
    req_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
  endtask

  rq_t burst[6] = '{'{1, 0, 0}, '{3, 2, 1}, '{0, 2, 2}, '{2, 0, 3}, '{3, 1, 3}, '{1, 2, 0}};

  initial begin
    int n, k, first_block, cnt, b;
    logic acc;

    n_reset = 1'b1; sync = 1'b0; req_valid = 1'b0;
    req_col = '0; req_row = '0; req_state = '0;
    #1 n_reset = 1'b0;
    #2;
    check("rst_pix_write", 32'(pix_write), 32'd0);
    check("rst_pix_x",     32'(pix_x),     32'd214);
    check("rst_pix_y",     32'(pix_y),     32'd32);
    check("rst_pix_color", 32'(pix_color), 32'h007);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_req_err",   32'(req_err),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    step();
    n_reset = 1'b1;
    step();
    check("ready_after_rst", 32'(req_ready), 32'd1);
    repeat (3) step();
    check("wait_no_writes", 32'(cap.size()), 32'd0);
    check("wait_busy",      32'(busy),       32'd0);

    // Power-up fill.
    pulse_sync();
    check("init_busy", 32'(busy), 32'd1);
    wait_writes(NINIT, NINIT + 100);
    repeat (5) step();
    check("init_count",  32'(cap.size()), 32'(NINIT));
    check("init_pixels", 32'(init_bad()), 32'd0);
    check("init_gaps",   32'(gaps(0, NINIT)), 32'd0);
    check("init_first_x", 32'(at(0).x), 32'd214);
    check("init_first_y", 32'(at(0).y), 32'd32);
    check("init_last_x",  32'(at(NINIT - 1).x), 32'(X0 + (COLS - 1) * PITCH + CELL - 1));
    check("init_last_y",  32'(at(NINIT - 1).y), 32'(Y0 + (ROWS - 1) * PITCH + CELL - 1));
    check("init_done",    32'(init_done), 32'd1);
    check("init_idle",    32'(busy), 32'd0);

    // Single request: latency and cell contents.
    cap.delete();
    send(2, 1, 1, n);
    wait_writes(NPIX, NPIX + 50);
    check("lat_first_cycle", 32'(at(0).cyc), 32'(n + 2));
    check("one_first_x", 32'(at(0).x), 32'd280);
    check("one_first_y", 32'(at(0).y), 32'd65);
    check("one_first_c", 32'(at(0).c), 32'h1FF);
    check("one_last_x",  32'(at(NPIX - 1).x), 32'd309);
    check("one_last_y",  32'(at(NPIX - 1).y), 32'd94);
    check("one_cell",    32'(cell_bad(0, 2, 1, 1)), 32'd0);
    repeat (5) step();
    check("one_count", 32'(cap.size()), 32'(NPIX));
    check("one_idle",  32'(busy), 32'd0);

    // Out-of-range requests: boundary column, boundary row.
    cap.delete();
    send(COLS, 0, 1, n);
    check("err_col_pulse", 32'(req_err), 32'd1);
    step();
    check("err_col_clear", 32'(req_err), 32'd0);
    send(0, ROWS, 2, n);
    check("err_row_pulse", 32'(req_err), 32'd1);
    step();
    check("err_row_clear", 32'(req_err), 32'd0);
    repeat (10) step();
    check("err_no_writes", 32'(cap.size()), 32'd0);
    check("err_ready",     32'(req_ready), 32'd1);

    // Back-to-back requests held during a draw.
    cap.delete();
    send(0, 0, 2, n);
    repeat (3) step();
    k = 0; first_block = -1; b = 4000;
    req_valid = 1'b1;
    req_col = 4'(burst[0].c); req_row = 4'(burst[0].r); req_state = 2'(burst[0].s);
    while (k < 6 && b > 0) begin
      @(negedge clk);
      if (!req_ready && first_block < 0) first_block = k;
      acc = req_ready;
      @(posedge clk);
      #1;
      b--;
      if (acc) begin
        k++;
        if (k < 6) begin
          req_col = 4'(burst[k].c); req_row = 4'(burst[k].r); req_state = 2'(burst[k].s);
        end
      end
    end
    req_valid = 1'b0;
    check("b2b_block_at", 32'(first_block), 32'd4);
    check("b2b_accepted", 32'(k), 32'd6);
    wait_writes(7 * NPIX, 8000);
    repeat (10) step();
    check("b2b_count", 32'(cap.size()), 32'(7 * NPIX));
    check("b2b_cell_a", 32'(cell_bad(0, 0, 0, 2)), 32'd0);
    for (int i = 0; i < 6; i++)
      check($sformatf("b2b_cell_%0d", i),
            32'(cell_bad((i + 1) * NPIX, burst[i].c, burst[i].r, burst[i].s)), 32'd0);
    check("b2b_gaps", 32'(gaps(0, 7 * NPIX)), 32'd0);
    check("b2b_idle", 32'(busy), 32'd0);

    // Reset in the middle of a draw with a second request still queued.
    cap.delete();
    send(1, 1, 2, n);
    send(2, 2, 1, n);
    wait_writes(400, 1000);
    #2 n_reset = 1'b0;
    #1;
    check("mid_rst_write", 32'(pix_write), 32'd0);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_done",  32'(init_done), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_x",     32'(pix_x),     32'd214);
    step();
    n_reset = 1'b1;
    cnt = cap.size();
    repeat (20) step();
    check("mid_rst_no_writes", 32'(cap.size()), 32'(cnt));
    check("mid_rst_ready_up",  32'(req_ready), 32'd1);

    // Refill after sync with two requests queued during the fill.
    cap.delete();
    pulse_sync();
    repeat (5) step();
    send(3, 2, 3, n);
    send(0, 1, 1, n);
    wait_writes(NINIT + 2 * NPIX, NINIT + 3 * NPIX);
    repeat (20) step();
    check("refill_count",  32'(cap.size()), 32'(NINIT + 2 * NPIX));
    check("refill_pixels", 32'(init_bad()), 32'd0);
    check("queued_cell_0", 32'(cell_bad(NINIT, 3, 2, 3)), 32'd0);
    check("queued_cell_1", 32'(cell_bad(NINIT + NPIX, 0, 1, 1)), 32'd0);
    check("queued_start",  32'(at(NINIT).cyc - at(NINIT - 1).cyc), 32'd2);
    check("queued_gaps",   32'(gaps(NINIT, NINIT + 2 * NPIX)), 32'd0);
    check("refill_done",   32'(init_done), 32'd1);
    check("refill_idle",   32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
